// File: rtl/aes_round_controller.sv
// Sequencing FSM for the iterative AES-128 inverse cipher: steps through load,
// key-expansion wait, the initial AddRoundKey, nine inverse rounds and the final round.
module aes_round_controller #(
  parameter int KEYEXP_CYCLES = 11
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       AES_START,
  input  logic       STEP_MODE,
  input  logic       CONTINUE,
  output logic       MSG_LD,
  output logic       STATE_LD,
  output logic [2:0] OP_SEL,
  output logic [3:0] ROUND,
  output logic [1:0] COL,
  output logic       BUSY,
  output logic       AES_DONE,
  output logic [3:0] DBG_STATE
);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_KEYEXP, S_ARK_INIT,
    S_R_ISR, S_R_ISB, S_R_ARK, S_R_IMC,
    S_F_ISR, S_F_ISB, S_F_ARK, S_DONE
  } state_t;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_ARK  = 3'd1;
  localparam logic [2:0] OP_ISR  = 3'd2;
  localparam logic [2:0] OP_ISB  = 3'd3;
  localparam logic [2:0] OP_IMC  = 3'd4;
  localparam logic [7:0] KEYEXP_LOAD = 8'(KEYEXP_CYCLES - 1);

  state_t     r_state;
  logic [7:0] r_cnt;
  logic [3:0] r_round;
  logic [1:0] r_col;
  logic [2:0] r_op_sel;
  logic       r_msg_ld;
  logic       r_busy;
  logic       r_done;

  logic w_op_state;
  logic w_adv;

  assign w_op_state = (r_state >= S_ARK_INIT) && (r_state <= S_F_ARK);
  assign w_adv      = !STEP_MODE || CONTINUE;
  // Dropping START suppresses the commit of the cycle in which the abort is taken.
  assign STATE_LD   = w_op_state && w_adv && AES_START;

  assign MSG_LD    = r_msg_ld;
  assign OP_SEL    = r_op_sel;
  assign ROUND     = r_round;
  assign COL       = r_col;
  assign BUSY      = r_busy;
  assign AES_DONE  = r_done;
  assign DBG_STATE = r_state;

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_round  <= 4'd0;
      r_col    <= 2'd0;
      r_op_sel <= OP_NONE;
      r_msg_ld <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (!AES_START && (r_state != S_IDLE)) begin
      // Abort from any active state, and the normal exit from DONE.
      r_state  <= S_IDLE;
      r_cnt    <= 8'd0;
      r_round  <= 4'd0;
      r_col    <= 2'd0;
      r_op_sel <= OP_NONE;
      r_msg_ld <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (AES_START) begin
            r_state  <= S_LOAD;
            r_msg_ld <= 1'b1;
            r_busy   <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state  <= S_KEYEXP;
          r_cnt    <= KEYEXP_LOAD;
          r_msg_ld <= 1'b0;
        end
        S_KEYEXP: begin
          if (r_cnt == 8'd0) begin
            r_state  <= S_ARK_INIT;
            r_round  <= 4'd10;
            r_op_sel <= OP_ARK;
          end else begin
            r_cnt <= r_cnt - 8'd1;
          end
        end
        S_ARK_INIT: begin
          if (w_adv) begin
            r_state  <= S_R_ISR;
            r_round  <= 4'd9;
            r_op_sel <= OP_ISR;
          end
        end
        S_R_ISR: begin
          if (w_adv) begin
            r_state  <= S_R_ISB;
            r_op_sel <= OP_ISB;
          end
        end
        S_R_ISB: begin
          if (w_adv) begin
            r_state  <= S_R_ARK;
            r_op_sel <= OP_ARK;
          end
        end
        S_R_ARK: begin
          if (w_adv) begin
            r_state  <= S_R_IMC;
            r_op_sel <= OP_IMC;
            r_col    <= 2'd0;
          end
        end
        S_R_IMC: begin
          if (w_adv) begin
            if (r_col != 2'd3) begin
              r_col <= r_col + 2'd1;
            end else if (r_round > 4'd1) begin
              r_state  <= S_R_ISR;
              r_round  <= r_round - 4'd1;
              r_col    <= 2'd0;
              r_op_sel <= OP_ISR;
            end else begin
              r_state  <= S_F_ISR;
              r_round  <= 4'd0;
              r_col    <= 2'd0;
              r_op_sel <= OP_ISR;
            end
          end
        end
        S_F_ISR: begin
          if (w_adv) begin
            r_state  <= S_F_ISB;
            r_op_sel <= OP_ISB;
          end
        end
        S_F_ISB: begin
          if (w_adv) begin
            r_state  <= S_F_ARK;
            r_op_sel <= OP_ARK;
          end
        end
        S_F_ARK: begin
          if (w_adv) begin
            r_state  <= S_DONE;
            r_op_sel <= OP_NONE;
            r_round  <= 4'd0;
            r_busy   <= 1'b0;
            r_done   <= 1'b1;
          end
        end
        S_DONE: begin
          r_state <= S_DONE;
        end
        default: begin
          r_state  <= S_IDLE;
          r_op_sel <= OP_NONE;
          r_busy   <= 1'b0;
          r_done   <= 1'b0;
        end
      endcase
    end
  end

endmodule
